// File: rtl/mac_step_sequencer.sv
// -----------------------------------------------------------------------------
// mac_step_sequencer
//
// Control sequencer for one dot-product row of the matrix multiplier. A start
// pulse clears the accumulator, then DIM element-address strobes are issued,
// each followed READ_LAT+1 cycles later by an accumulate strobe. In serial mode
// only one element is in flight at a time. In pipelined mode addresses go out
// back-to-back and a valid/last shift register times the accumulate strobes.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   start      begin a row (sampled only in IDLE)
//   pipe_mode  0 = serial, 1 = pipelined (latched together with start)
//   abort      synchronous cancel of the current row
//   busy       row in progress
//   acum_clr   one-cycle pulse: clear accumulator
//   gen_addr   one-cycle pulse per element: fetch operands
//   addr_idx   element index while gen_addr=1, 0 otherwise
//   acum       one-cycle pulse per element: accumulate fetched product
//   acum_last  qualifies acum for element DIM-1
//   done       one-cycle pulse: row complete
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mac_step_sequencer #(
    parameter int DIM      = 3,
    parameter int READ_LAT = 4,
    parameter int IDX_W    = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pipe_mode,
    input  logic             abort,
    output logic             busy,
    output logic             acum_clr,
    output logic             gen_addr,
    output logic [IDX_W-1:0] addr_idx,
    output logic             acum,
    output logic             acum_last,
    output logic             done
);

    localparam int                SR_D   = READ_LAT + 1;
    localparam int                WCNT_W = $clog2(READ_LAT + 1);
    localparam logic [IDX_W-1:0]  K_LAST = IDX_W'(DIM - 1);
    localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, ISSUE, WAIT, ACC, DRAIN, DONE
    } state_t;

    state_t            state, state_n;
    logic              mode, mode_n;
    logic [IDX_W-1:0]  k, k_n;
    logic [WCNT_W-1:0] wcnt, wcnt_n;
    logic [SR_D-1:0]   sr_vld, sr_vld_n;
    logic [SR_D-1:0]   sr_last, sr_last_n;

    logic              busy_n, clr_n, gen_n, acum_n, last_n, done_n;
    logic [IDX_W-1:0]  idx_n;
    logic              push;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        mode_n  = mode;
        k_n     = k;
        wcnt_n  = wcnt;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = CLEAR;
                    mode_n  = pipe_mode;
                    k_n     = '0;
                end
            end
            CLEAR: state_n = ISSUE;
            ISSUE: begin
                if (!mode) begin
                    state_n = WAIT;
                    wcnt_n  = '0;
                end else if (k == K_LAST) begin
                    state_n = DRAIN;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            WAIT: begin
                if (wcnt == W_LAST) state_n = ACC;
                else                wcnt_n  = wcnt + 1'b1;
            end
            ACC: begin
                if (k == K_LAST) begin
                    state_n = DONE;
                end else begin
                    k_n     = k + 1'b1;
                    state_n = ISSUE;
                end
            end
            // The last-tagged accumulate is on the outputs this cycle.
            DRAIN:   if (acum && acum_last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (abort && state != IDLE) begin
            state_n = IDLE;
            k_n     = '0;
            wcnt_n  = '0;
        end

        // Outputs are decoded from the next state so that, once registered,
        // they line up with the state they describe.
        busy_n = (state_n != IDLE);
        clr_n  = (state_n == CLEAR);
        gen_n  = (state_n == ISSUE);
        idx_n  = gen_n ? k_n : '0;
        done_n = (state_n == DONE);

        // Pipelined issues enter at bit 0; the top bit feeds the registered
        // acum, giving READ_LAT+1 cycles from gen_addr to acum.
        push      = mode_n && gen_n;
        sr_vld_n  = {sr_vld[SR_D-2:0], push};
        sr_last_n = {sr_last[SR_D-2:0], push && (k_n == K_LAST)};

        acum_n = (state_n == ACC) || sr_vld[SR_D-1];
        last_n = ((state_n == ACC) && (k_n == K_LAST)) ||
                 (sr_vld[SR_D-1] && sr_last[SR_D-1]);

        // In-flight elements are dropped on abort.
        if (abort && state != IDLE) begin
            sr_vld_n  = '0;
            sr_last_n = '0;
            acum_n    = 1'b0;
            last_n    = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values; the in-flight shift register is reset as well,
    // since a stale valid bit would emit a spurious accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= 1'b0;
            k         <= '0;
            wcnt      <= '0;
            sr_vld    <= '0;
            sr_last   <= '0;
            busy      <= 1'b0;
            acum_clr  <= 1'b0;
            gen_addr  <= 1'b0;
            addr_idx  <= '0;
            acum      <= 1'b0;
            acum_last <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            mode      <= mode_n;
            k         <= k_n;
            wcnt      <= wcnt_n;
            sr_vld    <= sr_vld_n;
            sr_last   <= sr_last_n;
            busy      <= busy_n;
            acum_clr  <= clr_n;
            gen_addr  <= gen_n;
            addr_idx  <= idx_n;
            acum      <= acum_n;
            acum_last <= last_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_mac_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_step_sequencer
//
// Directed bench for mac_step_sequencer. Instance a uses the default
// parameters (DIM=3, READ_LAT=4); instance b uses DIM=1, READ_LAT=1.
// Inputs change on the falling edge; the cycle counter c names the cycle after
// the rising edge that sampled start, and outputs are read mid-cycle.
// Output vector layout: {busy, acum_clr, gen_addr, addr_idx[1:0], acum,
// acum_last, done}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mac_step_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, pipe_mode, abort;
    logic       busy_a, clr_a, gen_a, acum_a, last_a, done_a;
    logic [1:0] idx_a;

    logic       rst_b, start_b, pipe_b, abort_b;
    logic       busy_b, clr_b, gen_b, acum_b, last_b, done_b;
    logic [0:0] idx_b;

    int n_assert = 0;
    int n_fail   = 0;

    mac_step_sequencer #(.DIM(3), .READ_LAT(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .pipe_mode(pipe_mode), .abort(abort),
        .busy(busy_a), .acum_clr(clr_a), .gen_addr(gen_a), .addr_idx(idx_a),
        .acum(acum_a), .acum_last(last_a), .done(done_a)
    );

    mac_step_sequencer #(.DIM(1), .READ_LAT(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .pipe_mode(pipe_b), .abort(abort_b),
        .busy(busy_b), .acum_clr(clr_b), .gen_addr(gen_b), .addr_idx(idx_b),
        .acum(acum_b), .acum_last(last_b), .done(done_b)
    );

    function automatic logic [7:0] pack_a();
        return {busy_a, clr_a, gen_a, idx_a, acum_a, last_a, done_a};
    endfunction

    function automatic logic [7:0] pack_b();
        return {busy_b, clr_b, gen_b, 1'b0, idx_b, acum_b, last_b, done_b};
    endfunction

    // Defaults, serial: clr 1; gen 2/8/14 idx 0/1/2; acum 7/13/19; last 19; done 20.
    function automatic logic [7:0] exp_serial(input int c);
        logic busy, clr, gen, acum, last, done;
        logic [1:0] idx;
        busy = (c >= 1 && c <= 20);
        clr  = (c == 1);
        gen  = 1'b0;
        idx  = 2'd0;
        case (c)
            2:  begin gen = 1'b1; idx = 2'd0; end
            8:  begin gen = 1'b1; idx = 2'd1; end
            14: begin gen = 1'b1; idx = 2'd2; end
            default: ;
        endcase
        acum = (c == 7 || c == 13 || c == 19);
        last = (c == 19);
        done = (c == 20);
        return {busy, clr, gen, idx, acum, last, done};
    endfunction

    // Defaults, pipelined: clr 1; gen 2,3,4 idx 0,1,2; acum 7,8,9; last 9; done 10.
    function automatic logic [7:0] exp_pipe(input int c);
        logic busy, clr, gen, acum, last, done;
        logic [1:0] idx;
        busy = (c >= 1 && c <= 10);
        clr  = (c == 1);
        gen  = 1'b0;
        idx  = 2'd0;
        case (c)
            2: begin gen = 1'b1; idx = 2'd0; end
            3: begin gen = 1'b1; idx = 2'd1; end
            4: begin gen = 1'b1; idx = 2'd2; end
            default: ;
        endcase
        acum = (c == 7 || c == 8 || c == 9);
        last = (c == 9);
        done = (c == 10);
        return {busy, clr, gen, idx, acum, last, done};
    endfunction

    // DIM=1, READ_LAT=1, either mode: clr 1; gen 2; acum+last 4; done 5.
    function automatic logic [7:0] exp_small(input int c);
        logic busy, clr, gen, acum, last, done;
        busy = (c >= 1 && c <= 5);
        clr  = (c == 1);
        gen  = (c == 2);
        acum = (c == 4);
        last = (c == 4);
        done = (c == 5);
        return {busy, clr, gen, 2'd0, acum, last, done};
    endfunction

    task automatic check(input string tag, input int c,
                         input logic [7:0] observed, input logic [7:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $display("FAIL %s cycle %0d: observed %b expected %b", tag, c, observed, expected);
            $error("check %s cycle %0d", tag, c);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pipe_mode = 1'b0; abort = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; pipe_b = 1'b0; abort_b = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_a", 0, pack_a(), 8'h00);
        check("reset_b", 0, pack_b(), 8'h00);
        rst = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("idle_a", 0, pack_a(), 8'h00);

        // 1: serial row, default parameters
        pipe_mode = 1'b0; start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check("serial", c, pack_a(), exp_serial(c));
        end

        // 2: pipelined row, default parameters
        pipe_mode = 1'b1; start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check("pipe", c, pack_a(), exp_pipe(c));
        end

        // 3: start at cycles 5 and 20 ignored, start in cycle 21 accepted;
        //    the second row is then aborted at cycle 23.
        pipe_mode = 1'b0; start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c <= 21)      check("restart", c, pack_a(), exp_serial(c));
            else if (c <= 23) check("restart", c, pack_a(), exp_serial(c - 21));
            else              check("restart", c, pack_a(), 8'h00);
            if (c == 1)  start = 1'b0;
            if (c == 5)  start = 1'b1;
            if (c == 6)  start = 1'b0;
            if (c == 20) start = 1'b1;
            if (c == 22) start = 1'b0;
            if (c == 23) abort = 1'b1;
            if (c == 24) abort = 1'b0;
        end

        // 4: pipelined row aborted at cycle 6, then a clean pipelined row
        pipe_mode = 1'b1; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check("pipe_abort", c, pack_a(), (c <= 6) ? exp_pipe(c) : 8'h00);
            if (c == 1) start = 1'b0;
            if (c == 6) abort = 1'b1;
            if (c == 7) abort = 1'b0;
        end
        start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check("pipe_after_abort", c, pack_a(), exp_pipe(c));
        end

        // 5: rst during WAIT of a serial row, then start together with abort
        pipe_mode = 1'b0; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("serial_rst", c, pack_a(), (c <= 4) ? exp_serial(c) : 8'h00);
            if (c == 1) start = 1'b0;
            if (c == 4) rst = 1'b1;
            if (c == 5) rst = 1'b0;
        end
        start = 1'b1; abort = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin start = 1'b0; abort = 1'b0; end
            check("start_abort", c, pack_a(), 8'h00);
        end

        // 6: DIM=1, READ_LAT=1, serial then pipelined
        pipe_b = 1'b0; start_b = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start_b = 1'b0;
            check("small_serial", c, pack_b(), exp_small(c));
        end
        pipe_b = 1'b1; start_b = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start_b = 1'b0;
            check("small_pipe", c, pack_b(), exp_small(c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
